// File: rtl/dmem_bus_pkg.sv
// Shared types and helpers for the data-memory bus arbiter.
//   arb_state_t : arbiter FSM states
//   mem_size_t  : access width (byte / half / word)
//   grant_t     : which requester owns the bus
//   F3_*        : RV32I load/store funct3 encodings
//   lane_sel()  : byte-select generation from size and addr[1:0]
//   is_misaligned() : natural-alignment check
package dmem_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} arb_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;
  typedef enum logic {GNT_CORE, GNT_DBG} grant_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic [3:0] lane_sel(input mem_size_t size, input logic [1:0] k);
    case (size)
      SZ_B:    return 4'b0001 << k;
      SZ_H:    return 4'b0011 << k;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] k);
    case (size)
      SZ_H:    return k[0];
      SZ_W:    return |k;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational byte-lane steering for both directions of the data bus.
// Request side:  req_size, req_k (addr[1:0]), req_wdata (right-aligned)
//                -> sel, wdata_steered (lane-replicated), misaligned
// Response side: rsp_size, rsp_k, rsp_signed, rsp_rdata_raw (bus word)
//                -> rsp_rdata (right-aligned, sign- or zero-extended)
module dmem_lane_steer
  import dmem_bus_pkg::*;
(
  input  mem_size_t   req_size,
  input  logic [1:0]  req_k,
  input  logic [31:0] req_wdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_steered,
  output logic        misaligned,
  input  mem_size_t   rsp_size,
  input  logic [1:0]  rsp_k,
  input  logic        rsp_signed,
  input  logic [31:0] rsp_rdata_raw,
  output logic [31:0] rsp_rdata
);

  logic [31:0] shifted;

  always_comb begin
    sel        = lane_sel(req_size, req_k);
    misaligned = is_misaligned(req_size, req_k);
    case (req_size)
      SZ_B:    wdata_steered = {4{req_wdata[7:0]}};
      SZ_H:    wdata_steered = {2{req_wdata[15:0]}};
      default: wdata_steered = req_wdata;
    endcase
  end

  always_comb begin
    shifted = rsp_rdata_raw >> {rsp_k, 3'b000};
    case (rsp_size)
      SZ_B:    rsp_rdata = {{24{rsp_signed & shifted[7]}}, shifted[7:0]};
      SZ_H:    rsp_rdata = {{16{rsp_signed & shifted[15]}}, shifted[15:0]};
      default: rsp_rdata = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Shares one Wishbone master between the core load/store port and the debug
// system-bus access port. Round-robin on simultaneous requests, lane
// steering, load extension, misalignment errors and a bus timeout.
// Ports:
//   clk, reset_n             : clock, async active-low reset
//   mem_*_mem, stall_pipl    : core MEM-stage request/response and stall
//   dbg_*                    : debug SBA request/response
//   wb_*_o / wb_*_i          : Wishbone master interface
module dmem_bus_arbiter
  import dmem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  mem_op_mem,
  output logic [31:0] mem_rdata_mem,
  output logic        mem_ack_mem,
  output logic        mem_err_mem,
  output logic        stall_pipl,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [1:0]  dbg_size,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        dbg_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  arb_state_t      state;
  grant_t          gnt;
  grant_t          last_grant;
  mem_size_t       rsp_size;
  logic [1:0]      rsp_k;
  logic            rsp_signed;
  logic [TO_W-1:0] to_cnt;

  logic        core_req;
  logic        core_bad;
  mem_size_t   core_size;
  mem_size_t   dbg_sz;
  logic        pick_dbg;

  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  mem_size_t   req_size;
  logic        req_signed;
  logic        req_bad;

  logic [3:0]  req_sel;
  logic [31:0] req_wdata_steered;
  logic        req_misaligned;
  logic [31:0] rsp_rdata;

  logic        timeout_hit;
  logic        fire;
  logic        fire_dbg;
  logic        fire_err;
  logic [31:0] fire_data;

  assign core_req   = mem_read_mem | mem_write_mem;
  assign stall_pipl = core_req & ~mem_ack_mem;

  // Debug wins only when the core is idle or the core was served last.
  assign pick_dbg = dbg_req & (~core_req | (last_grant == GNT_CORE));

  always_comb begin
    core_bad = !(mem_op_mem inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    case (mem_op_mem)
      F3_LB, F3_LBU: core_size = SZ_B;
      F3_LH, F3_LHU: core_size = SZ_H;
      default:       core_size = SZ_W;
    endcase
    case (dbg_size)
      2'd0:    dbg_sz = SZ_B;
      2'd1:    dbg_sz = SZ_H;
      default: dbg_sz = SZ_W;
    endcase
  end

  always_comb begin
    if (pick_dbg) begin
      req_we     = dbg_we;
      req_addr   = dbg_addr;
      req_wdata  = dbg_wdata;
      req_size   = dbg_sz;
      req_signed = 1'b0;
      req_bad    = (dbg_size == 2'd3);
    end else begin
      // Read and write both set is treated as a store.
      req_we     = mem_write_mem;
      req_addr   = mem_addr_mem;
      req_wdata  = mem_wdata_mem;
      req_size   = core_size;
      req_signed = ~mem_op_mem[2];
      req_bad    = core_bad;
    end
  end

  dmem_lane_steer u_steer (
    .req_size      (req_size),
    .req_k         (req_addr[1:0]),
    .req_wdata     (req_wdata),
    .sel           (req_sel),
    .wdata_steered (req_wdata_steered),
    .misaligned    (req_misaligned),
    .rsp_size      (rsp_size),
    .rsp_k         (rsp_k),
    .rsp_signed    (rsp_signed),
    .rsp_rdata_raw (wb_dat_i),
    .rsp_rdata     (rsp_rdata)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

  // Response for the RESP cycle, decided in the cycle before it. A slave
  // ack in the timeout cycle takes priority over the forced error.
  always_comb begin
    fire      = 1'b0;
    fire_dbg  = (gnt == GNT_DBG);
    fire_err  = 1'b0;
    fire_data = '0;
    case (state)
      IDLE: begin
        if ((core_req | dbg_req) && (req_bad | req_misaligned)) begin
          fire     = 1'b1;
          fire_dbg = pick_dbg;
          fire_err = 1'b1;
        end
      end
      ACTIVE: begin
        if (wb_ack_i | wb_err_i) begin
          fire      = 1'b1;
          fire_err  = wb_err_i;
          fire_data = (wb_err_i | wb_we_o) ? '0 : rsp_rdata;
        end else if (timeout_hit) begin
          fire     = 1'b1;
          fire_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      gnt           <= GNT_CORE;
      last_grant    <= GNT_DBG;
      rsp_size      <= SZ_B;
      rsp_k         <= '0;
      rsp_signed    <= 1'b0;
      to_cnt        <= '0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
      mem_ack_mem   <= 1'b0;
      mem_err_mem   <= 1'b0;
      mem_rdata_mem <= '0;
      dbg_ack       <= 1'b0;
      dbg_err       <= 1'b0;
      dbg_rdata     <= '0;
    end else begin
      mem_ack_mem   <= fire & ~fire_dbg;
      mem_err_mem   <= fire & ~fire_dbg & fire_err;
      mem_rdata_mem <= (fire & ~fire_dbg) ? fire_data : '0;
      dbg_ack       <= fire & fire_dbg;
      dbg_err       <= fire & fire_dbg & fire_err;
      dbg_rdata     <= (fire & fire_dbg) ? fire_data : '0;

      case (state)
        IDLE: begin
          if (core_req | dbg_req) begin
            gnt        <= pick_dbg ? GNT_DBG : GNT_CORE;
            last_grant <= pick_dbg ? GNT_DBG : GNT_CORE;
            rsp_size   <= req_size;
            rsp_k      <= req_addr[1:0];
            rsp_signed <= req_signed;
            if (req_bad | req_misaligned) begin
              state <= RESP;
            end else begin
              state    <= ACTIVE;
              to_cnt   <= '0;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= req_we;
              wb_adr_o <= {req_addr[31:2], 2'b00};
              wb_dat_o <= req_wdata_steered;
              wb_sel_o <= req_sel;
            end
          end
        end
        ACTIVE: begin
          if (fire) begin
            state    <= RESP;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
module tb_dmem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr_mem;
  logic [31:0] mem_wdata_mem;
  logic        mem_write_mem;
  logic        mem_read_mem;
  logic [2:0]  mem_op_mem;
  logic [31:0] mem_rdata_mem;
  logic        mem_ack_mem;
  logic        mem_err_mem;
  logic        stall_pipl;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [1:0]  dbg_size;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        dbg_err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  always #5 clk = ~clk;

  dmem_bus_arbiter #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr_mem  (mem_addr_mem),
    .mem_wdata_mem (mem_wdata_mem),
    .mem_write_mem (mem_write_mem),
    .mem_read_mem  (mem_read_mem),
    .mem_op_mem    (mem_op_mem),
    .mem_rdata_mem (mem_rdata_mem),
    .mem_ack_mem   (mem_ack_mem),
    .mem_err_mem   (mem_err_mem),
    .stall_pipl    (stall_pipl),
    .dbg_req       (dbg_req),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_size      (dbg_size),
    .dbg_rdata     (dbg_rdata),
    .dbg_ack       (dbg_ack),
    .dbg_err       (dbg_err),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_sel_o      (wb_sel_o),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_i      (wb_ack_i),
    .wb_err_i      (wb_err_i)
  );

  typedef struct {
    bit          is_dbg;
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];

  int checks;
  int passed;
  int fails;

  int          slv_wait;
  logic [31:0] slv_data;
  bit          slv_err;
  bit          slv_mute;

  int nc, nd, lim, nack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: acks (or errors) after slv_wait cycles of a strobed cycle.
  initial begin : slave
    int cnt;
    cnt      = 0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o && wb_stb_o && !slv_mute) begin
        if (cnt >= slv_wait) begin
          wb_ack_i = !slv_err;
          wb_err_i = slv_err;
          wb_dat_i = slv_data;
          cnt      = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: every ack pulse pops the oldest expected response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (mem_ack_mem || dbg_ack)) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({e.tag, "_grant"}, {30'd0, dbg_ack, mem_ack_mem}, e.is_dbg ? 32'd2 : 32'd1);
          chk({e.tag, "_rdata"}, e.is_dbg ? dbg_rdata : mem_rdata_mem, e.rdata);
          chk({e.tag, "_err"}, 32'(e.is_dbg ? dbg_err : mem_err_mem), 32'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic txn(input string tag, input bit is_dbg, input logic we,
                     input logic [2:0] code, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input int exp_lat, input int exp_cyc,
                     input logic [3:0] exp_sel, input logic [31:0] exp_wdat);
    int lat;
    int ncyc;
    bit got;
    bit seen;
    @(negedge clk);
    if (is_dbg) begin
      dbg_req   = 1'b1;
      dbg_we    = we;
      dbg_size  = code[1:0];
      dbg_addr  = addr;
      dbg_wdata = wdata;
    end else begin
      mem_read_mem  = !we;
      mem_write_mem = we;
      mem_op_mem    = code;
      mem_addr_mem  = addr;
      mem_wdata_mem = wdata;
    end
    sb.push_back('{is_dbg: is_dbg, rdata: exp_rdata, err: exp_err, tag: tag});
    #1 chk({tag, "_stall_req"}, 32'(stall_pipl), 32'(!is_dbg));
    lat  = 0;
    ncyc = 0;
    got  = 1'b0;
    seen = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (wb_cyc_o) begin
        ncyc++;
        if (!seen) begin
          seen = 1'b1;
          chk({tag, "_adr"}, wb_adr_o, {addr[31:2], 2'b00});
          chk({tag, "_sel"}, 32'(wb_sel_o), 32'(exp_sel));
          chk({tag, "_we"}, 32'(wb_we_o), 32'(we));
          if (we) chk({tag, "_wdat"}, wb_dat_o, exp_wdat);
        end
      end
      if (is_dbg ? dbg_ack : mem_ack_mem) got = 1'b1;
    end
    chk({tag, "_acked"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_cyc_cycles"}, 32'(ncyc), 32'(exp_cyc));
    chk({tag, "_stall_ack"}, 32'(stall_pipl), 32'd0);
    if (is_dbg) dbg_req = 1'b0;
    else begin
      mem_read_mem  = 1'b0;
      mem_write_mem = 1'b0;
    end
  endtask

  initial begin : stimulus
    checks = 0; passed = 0; fails = 0;
    slv_wait = 0; slv_data = '0; slv_err = 1'b0; slv_mute = 1'b0;
    reset_n = 1'b0;
    mem_addr_mem = '0; mem_wdata_mem = '0; mem_write_mem = 1'b0;
    mem_read_mem = 1'b0; mem_op_mem = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_size = '0;

    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_mem_ack", 32'(mem_ack_mem), 32'd0);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    chk("rst_mem_rdata", mem_rdata_mem, 32'd0);
    chk("rst_stall", 32'(stall_pipl), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Core accesses: lw, lb/lbu sign handling, sh steering, misaligned lw.
    slv_data = 32'hDEAD_BEEF;
    txn("lw_1004", 0, 0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 2, 1, 4'b1111, 32'h0);
    slv_data = 32'h80FF_FFFF;
    txn("lb_1003", 0, 0, 3'b000, 32'h0000_1003, 32'h0, 32'hFFFF_FF80, 0, 2, 1, 4'b1000, 32'h0);
    txn("lbu_1003", 0, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h0000_0080, 0, 2, 1, 4'b1000, 32'h0);
    txn("sh_2002", 0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 2, 1, 4'b1100, 32'hABCD_ABCD);
    txn("lw_mis_1002", 0, 0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 1, 1, 0, 4'b0000, 32'h0);

    // Wait-state slave and slave error.
    slv_wait = 1; slv_data = 32'h8001_0000;
    txn("lh_7002_ws", 0, 0, 3'b001, 32'h0000_7002, 32'h0, 32'hFFFF_8001, 0, 3, 2, 4'b1100, 32'h0);
    slv_wait = 0; slv_err = 1'b1;
    txn("lhu_7002_err", 0, 0, 3'b101, 32'h0000_7002, 32'h0, 32'h0, 1, 2, 1, 4'b1100, 32'h0);
    slv_err = 1'b0;

    // Debug port: zero-extended byte read, byte write, illegal size, misaligned half.
    slv_data = 32'h80FF_FFFF;
    txn("dbg_rb_4003", 1, 0, 3'd0, 32'h0000_4003, 32'h0, 32'h0000_0080, 0, 2, 1, 4'b1000, 32'h0);
    txn("dbg_wb_4002", 1, 1, 3'd0, 32'h0000_4002, 32'h0000_00A5, 32'h0, 0, 2, 1, 4'b0100, 32'hA5A5_A5A5);
    txn("dbg_size3", 1, 0, 3'd3, 32'h0000_4000, 32'h0, 32'h0, 1, 1, 0, 4'b0000, 32'h0);
    txn("dbg_rh_mis", 1, 0, 3'd1, 32'h0000_4001, 32'h0, 32'h0, 1, 1, 0, 4'b0000, 32'h0);

    // Simultaneous requests, both held: core, dbg, core, dbg.
    slv_data = 32'h1234_5678;
    @(negedge clk);
    mem_read_mem = 1'b1; mem_write_mem = 1'b0; mem_op_mem = 3'b000;
    mem_addr_mem = 32'h0000_3003;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_size = 2'd0; dbg_addr = 32'h0000_4001;
    sb.push_back('{is_dbg: 1'b0, rdata: 32'h0000_0012, err: 1'b0, tag: "arb_c1"});
    sb.push_back('{is_dbg: 1'b1, rdata: 32'h0000_0056, err: 1'b0, tag: "arb_d1"});
    sb.push_back('{is_dbg: 1'b0, rdata: 32'h0000_0012, err: 1'b0, tag: "arb_c2"});
    sb.push_back('{is_dbg: 1'b1, rdata: 32'h0000_0056, err: 1'b0, tag: "arb_d2"});
    nc = 0; nd = 0; lim = 0;
    while ((nc < 2 || nd < 2) && lim < 100) begin
      @(negedge clk);
      lim++;
      if (mem_ack_mem) begin
        nc++;
        if (nc == 2) mem_read_mem = 1'b0;
      end
      if (dbg_ack) begin
        nd++;
        if (nd == 2) dbg_req = 1'b0;
      end
    end
    chk("arb_core_grants", 32'(nc), 32'd2);
    chk("arb_dbg_grants", 32'(nd), 32'd2);

    // Unresponsive slave: four ACTIVE cycles then forced error.
    slv_mute = 1'b1;
    txn("lw_timeout", 0, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 1, 5, 4, 4'b1111, 32'h0);

    // Reset in ACTIVE: cycle drops at once, no response follows.
    @(negedge clk);
    mem_read_mem = 1'b1; mem_op_mem = 3'b010; mem_addr_mem = 32'h0000_6000;
    @(negedge clk);
    chk("rst_mid_cyc_before", 32'(wb_cyc_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cyc_drop", 32'(wb_cyc_o), 32'd0);
    chk("rst_mid_stb_drop", 32'(wb_stb_o), 32'd0);
    mem_read_mem = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    slv_mute = 1'b0;
    nack = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ack_mem || dbg_ack) nack++;
    end
    chk("rst_mid_no_ack", 32'(nack), 32'd0);

    slv_data = 32'hCAFE_F00D;
    txn("lw_after_rst", 0, 0, 3'b010, 32'h0000_1008, 32'h0, 32'hCAFE_F00D, 0, 2, 1, 4'b1111, 32'h0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
